alu_result_serial_ctrl: RTL
===========================

// Module: alu_result_serial_ctrl
// PURPOSE
//  Sequencer for the ALU-result serial output path. Debounces push-button BUT1
//  and selects an ALU operation via op_sel. Captures the registered ALU result
//  and shifts it MSB-first on a divided bit clock with a frame strobe.
//  Sits between the button input, the ALU op/result datapath and the serial pins.
// PARAMETERS
//  DATA_W          8        result width / bits per frame
//  OP_COUNT        8        number of ALU ops; op_sel wraps OP_COUNT-1 -> 0
//  DEBOUNCE_CYCLES 1000000  CLK cycles BUT1 must be stable before accepted (>=1)
//  BIT_DIV         50       CLK cycles per serial bit; even, >=2
// PORTS
//  CLK         in   1                      system clock, all logic on posedge
//  RST         in   1                      synchronous, active-high reset
//  BUT1        in   1                      raw async button, active-high
//  op_sel      out  $clog2(OP_COUNT)       ALU operation select to datapath
//  alu_result  in   DATA_W                 ALU result; valid 1 cycle after op_sel
//  ser_data    out  1                      serial data, MSB first
//  ser_clk     out  1                      bit clock; receiver samples on rise
//  ser_frame   out  1                      high for the whole DATA_W-bit word
//  busy        out  1                      high from press acceptance to done
//  done        out  1                      1-cycle pulse after frame ends
// BEHAVIOUR
//  Reset (RST=1 at posedge): op_sel=0, ser_data=0, ser_clk=0, ser_frame=0,
//   busy=0, done=0, pending=0, FSM=IDLE, debounce counter=0, btn_level=0.
//   RST mid-frame aborts immediately; no partial done pulse.
//  Input path: BUT1 -> 2-FF synchronizer -> debouncer. btn_level follows the
//   synced value only after DEBOUNCE_CYCLES consecutive cycles that differ
//   from btn_level. Any bounce restarts the count. press = 1-cycle rise of btn_level.
//  FSM states and transitions:
//   IDLE    : busy=0. press or pending -> SELECT (clear pending, busy=1).
//   SELECT  : 1 cycle; op_sel stable; waits the datapath 1-cycle latency.
//   CAPTURE : 1 cycle; sreg<=alu_result. -> SHIFT with ser_frame=1,
//             ser_data=alu_result[DATA_W-1], ser_clk=0, bit_cnt=0, phase=0.
//   SHIFT   : phase counts 0..BIT_DIV/2-1. At terminal count ser_clk toggles.
//             On 0->1 data is held. On 1->0 bit_cnt++ and the next bit
//             (sreg shifted left) drives ser_data. After the high phase of
//             bit DATA_W-1: ser_clk=0, ser_frame=0, ser_data=0 -> DONE.
//   DONE    : 1 cycle; done=1, op_sel<=(op_sel==OP_COUNT-1)?0:op_sel+1.
//             -> IDLE.
//  Timing: first ser_frame rise 3 cycles after the press cycle.
//   A frame lasts DATA_W*BIT_DIV cycles. done asserts the cycle after ser_frame falls.
//  Press while busy: sets pending (1-deep). Further presses are dropped.
//   A press in the same cycle as DONE also sets pending.
//   A pending press starts the next frame with the advanced op_sel.
//  op_sel changes only in DONE and is never changed mid-frame.
//  ser_data changes only while ser_clk=0 (setup = BIT_DIV/2 cycles).
// TESTING (bench: DEBOUNCE_CYCLES=4, BIT_DIV=4, DATA_W=8, OP_COUNT=8)
//  1 Reset: hold RST 3 cycles with BUT1 toggling -> all outputs 0, op_sel=0,
//    no frame after release.
//  2 Single press: alu_result=8'h09 for op 0, BUT1 high 20 cycles ->
//    ser_frame high 32 cycles, bits 0,0,0,0,1,0,0,1 sampled on ser_clk rises;
//    done pulse; op_sel=1.
//  3 Bounce: BUT1 pulses of 1-3 cycles separated by lows -> no press, busy
//    stays 0. A 4-cycle-stable high -> exactly one frame.
//  4 Pending: 3 presses during one frame -> exactly 2 frames (ops 0 then 1),
//    op_sel=2 after; second ser_frame rises 4 cycles after first done.
//  5 Wrap: 8 sequential presses -> op_sel sequence 0..7 then 0.
//    Each frame matches the model result (e.g. A=5,B=4: 09,01,04,05,00,01,01,01).
//  6 Reset mid-frame: assert RST at bit 3 -> next cycle ser_frame=0, ser_clk=0,
//    busy=0, done never pulses, op_sel=0.

Source files
------------

// File: rtl/alu_result_serial_ctrl.sv
// -----------------------------------------------------------------------------
// alu_result_serial_ctrl
//
// Sequencer for the ALU-result serial output path. A debounced press of BUT1
// starts one frame: the current op_sel is held for the datapath latency, the
// ALU result is captured and then shifted out MSB-first on a divided bit clock
// while ser_frame is high. After each frame op_sel advances (wrapping at
// OP_COUNT-1). One press arriving while a frame is in flight is remembered and
// starts the next frame automatically.
//
// Ports
//   CLK         in   1          system clock, all logic on posedge
//   RST         in   1          synchronous, active-high reset
//   BUT1        in   1          raw asynchronous push button, active-high
//   op_sel      out  OP_W       ALU operation select to the datapath
//   alu_result  in   DATA_W     ALU result, valid one cycle after op_sel
//   ser_data    out  1          serial data, MSB first
//   ser_clk     out  1          bit clock, receiver samples on the rising edge
//   ser_frame   out  1          high for the whole DATA_W-bit word
//   busy        out  1          high from press acceptance until done
//   done        out  1          one-cycle pulse after the frame ends
// -----------------------------------------------------------------------------
module alu_result_serial_ctrl #(
    parameter int DATA_W          = 8,
    parameter int OP_COUNT        = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BIT_DIV         = 50,
    localparam int OP_W           = (OP_COUNT > 1) ? $clog2(OP_COUNT) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BUT1,
    output logic [OP_W-1:0]   op_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              ser_data,
    output logic              ser_clk,
    output logic              ser_frame,
    output logic              busy,
    output logic              done
);

    localparam int HALF_DIV = BIT_DIV / 2;
    localparam int PH_W     = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(OP_COUNT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Button input path
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_db_cnt;
    logic             r_btn_level;
    logic             r_btn_prev;
    logic             w_press;

    // Sequencer state
    state_t            r_state;
    logic              r_pending;
    logic [OP_W-1:0]   r_op_sel;
    logic [DATA_W-1:0] r_sreg;      // bits still to send, next bit in the MSB
    logic [PH_W-1:0]   r_phase;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_ser_data;
    logic              r_ser_clk;
    logic              r_ser_frame;
    logic              r_busy;
    logic              r_done;

    // Synchronise BUT1 and accept a new level only after it has differed from
    // the accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_db_cnt    <= '0;
            r_btn_level <= 1'b0;
            r_btn_prev  <= 1'b0;
        end else begin
            r_sync1    <= BUT1;
            r_sync2    <= r_sync1;
            r_btn_prev <= r_btn_level;
            if (r_sync2 != r_btn_level) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_level <= r_sync2;
                    r_db_cnt    <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                // any bounce back to the accepted level restarts the count
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press = r_btn_level & ~r_btn_prev;

    // Frame sequencer: select, capture, shift out, advance op_sel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_op_sel    <= '0;
            r_sreg      <= '0;
            r_phase     <= '0;
            r_bit_cnt   <= '0;
            r_ser_data  <= 1'b0;
            r_ser_clk   <= 1'b0;
            r_ser_frame <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // one press is remembered while busy (including the DONE cycle)
            if ((r_state != ST_IDLE) && w_press) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_press || r_pending) begin
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SELECT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    // op_sel already stable; this cycle covers the ALU latency
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_ser_data  <= alu_result[DATA_W-1];
                    r_sreg      <= {alu_result[DATA_W-2:0], 1'b0};
                    r_ser_frame <= 1'b1;
                    r_ser_clk   <= 1'b0;
                    r_bit_cnt   <= '0;
                    r_phase     <= '0;
                    r_state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (r_phase == PH_LAST) begin
                        r_phase <= '0;
                        if (!r_ser_clk) begin
                            r_ser_clk <= 1'b1;          // data held across the rise
                        end else begin
                            r_ser_clk <= 1'b0;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_ser_frame <= 1'b0;
                                r_ser_data  <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= ST_DONE;
                            end else begin
                                // next bit changes together with the falling edge
                                r_bit_cnt  <= r_bit_cnt + 1'b1;
                                r_ser_data <= r_sreg[DATA_W-1];
                                r_sreg     <= {r_sreg[DATA_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_op_sel <= (r_op_sel == OP_LAST) ? '0 : (r_op_sel + 1'b1);
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_sel    = r_op_sel;
    assign ser_data  = r_ser_data;
    assign ser_clk   = r_ser_clk;
    assign ser_frame = r_ser_frame;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
